// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and packed-SIMD lane modes.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    PACK_WORD    = 2'b00,
    PACK_HALF    = 2'b01,
    PACK_BYTE    = 2'b10,
    PACK_ILLEGAL = 2'b11
  } pack_mode_t;

endpackage

// File: rtl/adder32.sv
// Packed 32-bit adder: one word, two 16-bit halves or four 8-bit bytes.
// Lanes wrap independently; an illegal mode yields zero.
module adder32
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  pack_mode_t      mode,
  output logic [XLEN-1:0] sum
);

  logic [XLEN-1:0] word_sum;
  logic [XLEN-1:0] half_sum;
  logic [XLEN-1:0] byte_sum;

  assign word_sum = a + b;

  // Each lane is a separate adder, so no carry can leak across a lane boundary.
  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign half_sum[gi*16 +: 16] = a[gi*16 +: 16] + b[gi*16 +: 16];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign byte_sum[gi*8 +: 8] = a[gi*8 +: 8] + b[gi*8 +: 8];
  end

  always_comb begin
    sum = '0;
    case (mode)
      PACK_WORD: sum = word_sum;
      PACK_HALF: sum = half_sum;
      PACK_BYTE: sum = byte_sum;
      default:   sum = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req starting at ptr, wrapping, and grants the
// first requester found. gnt stays zero when en is low.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one packed adder32 among NUM_REQ requesters with a registered, tagged
// response slot. Define ADDER_ARBITER_STATS_EN to add grant/stall counters.
module adder_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_a,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_b,
  input  logic [NUM_REQ-1:0][1:0]       req_mode,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [XLEN-1:0]               rsp_data,
  output logic                          rsp_err
`ifdef ADDER_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ-1:0][XLEN-1:0]  stat_grants,
  output logic [XLEN-1:0]               stat_stall
`endif
);

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

  slot_state_t      state_reg, state_next;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  rsp_id_reg;
  logic [XLEN-1:0]  rsp_data_reg;
  logic             rsp_err_reg;

  logic             can_accept;
  logic             accept;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic [XLEN-1:0]  sel_a;
  logic [XLEN-1:0]  sel_b;
  logic [1:0]       sel_mode;
  logic [XLEN-1:0]  add_sum;

  assign rsp_valid = (state_reg == SLOT_FULL);
  // A full slot being drained this cycle can take a new op without a bubble.
  assign can_accept = !rsp_valid || rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_reg),
    .en      (can_accept && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign sel_a     = req_a[gnt_idx];
  assign sel_b     = req_b[gnt_idx];
  assign sel_mode  = req_mode[gnt_idx];

  adder32 u_adder32 (
    .a    (sel_a),
    .b    (sel_b),
    .mode (pack_mode_t'(sel_mode)),
    .sum  (add_sum)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SLOT_EMPTY: if (accept) state_next = SLOT_FULL;
      SLOT_FULL:  if (rsp_ready && !accept) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= SLOT_EMPTY;
      rr_ptr_reg   <= '0;
      rsp_id_reg   <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rsp_id_reg   <= gnt_idx;
        rsp_data_reg <= add_sum;
        rsp_err_reg  <= (sel_mode == PACK_ILLEGAL);
        rr_ptr_reg   <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign rsp_id   = rsp_id_reg;
  assign rsp_data = rsp_data_reg;
  assign rsp_err  = rsp_err_reg;

`ifdef ADDER_ARBITER_STATS_EN
  logic [NUM_REQ-1:0][XLEN-1:0] stat_grants_reg;
  logic [XLEN-1:0]              stat_stall_reg;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    always_ff @(posedge clk) begin
      if (rst) stat_grants_reg[gi] <= '0;
      else if (gnt[gi]) stat_grants_reg[gi] <= stat_grants_reg[gi] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stat_stall_reg <= '0;
    else if ((|req_valid) && !accept) stat_stall_reg <= stat_stall_reg + 1'b1;
  end

  assign stat_grants = stat_grants_reg;
  assign stat_stall  = stat_stall_reg;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed-vector bench for adder_arbiter with NUM_REQ=2.
module tb_adder_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_a;
  logic [1:0][31:0]  req_b;
  logic [1:0][1:0]   req_mode;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:0]        rsp_id;
  logic [31:0]       rsp_data;
  logic              rsp_err;
`ifdef ADDER_ARBITER_STATS_EN
  logic [1:0][31:0]  stat_grants;
  logic [31:0]       stat_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
`ifdef ADDER_ARBITER_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  // Response tuple {valid, id, err, data} compared as one value per vector.
  logic [34:0] rsp_tuple;
  assign rsp_tuple = {rsp_valid, rsp_id, rsp_err, rsp_data};

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b expected 00", req_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (rsp_tuple !== 35'h0) begin
      n_err++; $display("FAIL reset_rsp: got %h expected %h", rsp_tuple, 35'h0);
    end
    $display("reset: req_ready=%b rsp_valid=%b", req_ready, rsp_valid);
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ready;
    logic [34:0] exp_rsp;
    @(negedge clk);
    req_a[0] = 32'h10; req_b[0] = 32'h01; req_mode[0] = 2'b00;
    req_a[1] = 32'h20; req_b[1] = 32'h02; req_mode[1] = 2'b00;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_rsp   = (i % 2 == 0) ? {1'b1, 1'b0, 1'b0, 32'h11} : {1'b1, 1'b1, 1'b0, 32'h22};
      n_vec++;
      if (req_ready !== exp_ready) begin
        n_err++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, req_ready, exp_ready);
      end
      @(posedge clk); #1;
      n_vec++;
      if (rsp_tuple !== exp_rsp) begin
        n_err++; $display("FAIL rr_rsp[%0d]: got %h expected %h", i, rsp_tuple, exp_rsp);
      end
      $display("rr op %0d: id=%0d data=%h", i, rsp_id, rsp_data);
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rr_drain: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req_a[0] = 32'h0000_00FF; req_b[0] = 32'h0000_0001; req_mode[0] = 2'b00;
    req_valid = 2'b01;
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (rsp_tuple !== {1'b1, 1'b0, 1'b0, 32'h0000_0100}) begin
      n_err++; $display("FAIL single_rsp: got %h expected %h", rsp_tuple, {1'b1, 1'b0, 1'b0, 32'h0000_0100});
    end
    $display("single op: id=%0d data=%h err=%b", rsp_id, rsp_data, rsp_err);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_drain: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] va [3] = '{32'h00FF_FFFF, 32'h00FF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vb [3] = '{32'h0001_0001, 32'h0001_0001, 32'h0101_0101};
    logic [1:0]  vm [3] = '{2'b00, 2'b01, 2'b10};
    logic [31:0] ve [3] = '{32'h0101_0000, 32'h0100_0000, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_a[0] = va[i]; req_b[0] = vb[i]; req_mode[0] = vm[i];
      req_valid = 2'b01;
      @(posedge clk); #1;
      n_vec++;
      if (rsp_tuple !== {1'b1, 1'b0, 1'b0, ve[i]}) begin
        n_err++; $display("FAIL lane[%0d]: got %h expected %h", i, rsp_tuple, {1'b1, 1'b0, 1'b0, ve[i]});
      end
      $display("lane op mode=%b: data=%h", vm[i], rsp_data);
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    // Slot is empty and rr_ptr is 1 on entry.
    @(negedge clk);
    req_a[0] = 32'h1; req_b[0] = 32'h2; req_mode[0] = 2'b00;
    req_valid = 2'b01; rsp_ready = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_tuple !== {1'b1, 1'b0, 1'b0, 32'h3}) begin
      n_err++; $display("FAIL bp_fill: got %h expected %h", rsp_tuple, {1'b1, 1'b0, 1'b0, 32'h3});
    end
    @(negedge clk);
    req_a[1] = 32'h100; req_b[1] = 32'h23; req_mode[1] = 2'b00;
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (req_ready !== 2'b00) begin
        n_err++; $display("FAIL bp_ready[%0d]: got %b expected 00", i, req_ready);
      end
      @(posedge clk); #1;
      n_vec++;
      if (rsp_tuple !== {1'b1, 1'b0, 1'b0, 32'h3}) begin
        n_err++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, rsp_tuple, {1'b1, 1'b0, 1'b0, 32'h3});
      end
      $display("stall cycle %0d: rsp_data=%h", i, rsp_data);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL bp_release_ready: got %b expected 10", req_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (rsp_tuple !== {1'b1, 1'b1, 1'b0, 32'h123}) begin
      n_err++; $display("FAIL bp_release_rsp: got %h expected %h", rsp_tuple, {1'b1, 1'b1, 1'b0, 32'h123});
    end
    $display("drain+accept: id=%0d data=%h", rsp_id, rsp_data);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    @(negedge clk);
    req_a[0] = 32'h5; req_b[0] = 32'h7; req_mode[0] = 2'b11;
    req_valid = 2'b01; rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_tuple !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
      n_err++; $display("FAIL illegal_rsp: got %h expected %h", rsp_tuple, {1'b1, 1'b0, 1'b1, 32'h0});
    end
    $display("illegal op: err=%b data=%h", rsp_err, rsp_data);
    @(negedge clk);
    req_mode[0] = 2'b00;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_tuple !== {1'b1, 1'b0, 1'b0, 32'hC}) begin
      n_err++; $display("FAIL illegal_next: got %h expected %h", rsp_tuple, {1'b1, 1'b0, 1'b0, 32'hC});
    end
    $display("legal op after illegal: err=%b data=%h", rsp_err, rsp_data);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    // Fill the slot from requester 0 so rr_ptr moves to 1 before reset.
    @(negedge clk);
    req_a[0] = 32'h40; req_b[0] = 32'h2; req_mode[0] = 2'b00;
    req_valid = 2'b01; rsp_ready = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL rstmid_fill: got %b expected 1", rsp_valid);
    end
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b11;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_discard: got %b expected 0", rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b1;
    req_a[1] = 32'h7; req_b[1] = 32'h1; req_mode[1] = 2'b00;
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL rstmid_ptr: got %b expected 01", req_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (rsp_tuple !== {1'b1, 1'b0, 1'b0, 32'h42}) begin
      n_err++; $display("FAIL rstmid_first: got %h expected %h", rsp_tuple, {1'b1, 1'b0, 1'b0, 32'h42});
    end
    $display("post-reset grant: id=%0d data=%h", rsp_id, rsp_data);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_mode = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_round_robin();
    test_single();
    test_lanes();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
